// File: rtl/mix_sequencer_if.sv
// mix_sequencer_if: frame/sample/gain inputs and mixed-output signals of the mix sequencer.
interface mix_sequencer_if #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 24,
  parameter int GAIN_W = 8
);
  logic                     frame_start;
  logic [NUM_CH*DATA_W-1:0] in_l;
  logic [NUM_CH*DATA_W-1:0] in_r;
  logic [NUM_CH*GAIN_W-1:0] gain;
  logic                     overrun_clr;
  logic [DATA_W-1:0]        l_out;
  logic [DATA_W-1:0]        r_out;
  logic                     out_valid;
  logic                     busy;
  logic                     overrun;
  modport master (
    output frame_start, in_l, in_r, gain, overrun_clr,
    input  l_out, r_out, out_valid, busy, overrun
  );
  modport slave (
    input  frame_start, in_l, in_r, gain, overrun_clr,
    output l_out, r_out, out_valid, busy, overrun
  );
endinterface

// File: rtl/mix_sequencer.sv
// mix_sequencer: per-frame gain-and-sum of NUM_CH stereo channels through one shared multiplier.
// Define MIX_SEQ_SAT_EN to clamp the sums; otherwise the sums are averaged by NUM_CH.
module mix_sequencer #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 24,
  parameter int GAIN_W = 8
) (
  input logic             clk,
  input logic             rst,
  mix_sequencer_if.slave  bus
);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int AW = DATA_W + 2 + $clog2(NUM_CH);
  typedef enum logic [1:0] {IDLE, MAC_L, MAC_R, FINAL} state_t;
  state_t                     state, state_n;
  logic [CW-1:0]              ch;
  logic [NUM_CH*DATA_W-1:0]   snap_l, snap_r;
  logic [NUM_CH*GAIN_W-1:0]   snap_g;
  logic signed [AW-1:0]       acc, acc_l, sum, term;
  logic signed [DATA_W-1:0]   smp;
  logic [GAIN_W-1:0]          g;
  logic signed [DATA_W+GAIN_W:0] prod;
  logic [DATA_W-1:0]          red_l, red_r;
  logic                       last;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    last = ch == CW'(NUM_CH - 1);
    state_n = state == IDLE  ? (bus.frame_start ? MAC_L : IDLE) :
              state == MAC_L ? (last ? MAC_R : MAC_L) :
              state == MAC_R ? (last ? FINAL : MAC_R) : IDLE;
  end
  assign bus.busy = state != IDLE;
  // single multiplier: operand muxed by MAC state, gain zero-extended to stay unsigned
  always_comb begin
    smp  = state == MAC_R ? snap_r[ch*DATA_W +: DATA_W] : snap_l[ch*DATA_W +: DATA_W];
    g    = snap_g[ch*GAIN_W +: GAIN_W];
    prod = smp * $signed({1'b0, g});
    term = AW'(prod >>> 7);
    sum  = acc + term;
  end
`ifdef MIX_SEQ_SAT_EN
  localparam logic signed [AW-1:0] MAXV = {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = ~MAXV;
  always_comb begin
    red_l = acc_l > MAXV ? MAXV[DATA_W-1:0] : acc_l < MINV ? MINV[DATA_W-1:0] : acc_l[DATA_W-1:0];
    red_r = acc   > MAXV ? MAXV[DATA_W-1:0] : acc   < MINV ? MINV[DATA_W-1:0] : acc[DATA_W-1:0];
  end
`else
  localparam int SH = $clog2(NUM_CH);
  always_comb begin
    red_l = DATA_W'(acc_l >>> SH);
    red_r = DATA_W'(acc >>> SH);
  end
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ch            <= '0;
      acc           <= '0;
      acc_l         <= '0;
      snap_l        <= '0;
      snap_r        <= '0;
      snap_g        <= '0;
      bus.l_out     <= '0;
      bus.r_out     <= '0;
      bus.out_valid <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      bus.out_valid <= state == FINAL;
      bus.overrun   <= (bus.frame_start && state != IDLE) || (bus.overrun && !bus.overrun_clr);
      if (state == IDLE && bus.frame_start) begin
        snap_l <= bus.in_l;
        snap_r <= bus.in_r;
        snap_g <= bus.gain;
        acc    <= '0;
        ch     <= '0;
      end
      if (state == MAC_L || state == MAC_R) begin
        acc <= (state == MAC_L && last) ? '0 : sum;
        ch  <= last ? '0 : ch + 1'b1;
        if (state == MAC_L && last) acc_l <= sum;
      end
      if (state == FINAL) begin
        bus.l_out <= red_l;
        bus.r_out <= red_r;
      end
    end
endmodule

// File: tb/tb_mix_sequencer.sv
// tb_mix_sequencer: table vectors, hand-written corner sequences and random frames vs a behavioural mix model.
module tb_mix_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  always #5 clk = ~clk;
  mix_sequencer_if #(.NUM_CH(2), .DATA_W(24), .GAIN_W(8)) bus();
  mix_sequencer #(.NUM_CH(2), .DATA_W(24), .GAIN_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [47:0] l;
    logic [47:0] r;
    logic [15:0] g;
    logic [23:0] el;
    logic [23:0] er;
  } vec_t;
  vec_t vt[4];
  // each channel contributes floor(sample*gain/128); then clamp or average
  function automatic logic [23:0] model(input logic [47:0] x, input logic [15:0] gn);
    longint s = 0;
    for (int k = 0; k < 2; k++) begin
      longint v = longint'($signed(x[k*24 +: 24]));
      longint gg = longint'(gn[k*8 +: 8]);
      s += (v * gg) >>> 7;
    end
`ifdef MIX_SEQ_SAT_EN
    if (s > 64'sd8388607) s = 64'sd8388607;
    if (s < -64'sd8388608) s = -64'sd8388608;
`else
    s = s >>> 1;
`endif
    return s[23:0];
  endfunction
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // launches one frame and watches 16 cycles; cycle k = k-th falling edge after the accepting edge
  task automatic run_frame(input logic [47:0] l, input logic [47:0] r, input logic [15:0] g,
                           output int lat, output int strobes, output logic [23:0] lo, output logic [23:0] ro);
    @(negedge clk);
    bus.in_l = l; bus.in_r = r; bus.gain = g; bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    lat = 0; strobes = 0; lo = '0; ro = '0;
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) @(negedge clk);
      if (bus.out_valid) begin
        strobes++;
        if (lat == 0) begin lat = k; lo = bus.l_out; ro = bus.r_out; end
      end
    end
  endtask
  function automatic logic [23:0] rnd_smp();
    int p = int'($urandom_range(0, 5));
    return p == 0 ? 24'h7FFFFF : p == 1 ? 24'h800000 : 24'($urandom);
  endfunction
  initial begin
    int lat, strobes, hi_seen, c1, c2;
    logic [23:0] lo, ro, el, er;
    logic [47:0] l, r;
    logic [15:0] g;
    bus.frame_start = 1'b0; bus.overrun_clr = 1'b0;
    bus.in_l = '0; bus.in_r = '0; bus.gain = '0;
`ifdef MIX_SEQ_SAT_EN
    vt[0] = '{48'h100000_100000, 48'hF80000_080000, 16'h8080, 24'h200000, 24'h000000};
    vt[1] = '{48'h123456_400000, 48'h000000_000000, 16'h0040, 24'h200000, 24'h000000};
    vt[2] = '{48'h7FFFFF_7FFFFF, 48'h7FFFFF_7FFFFF, 16'hFFFF, 24'h7FFFFF, 24'h7FFFFF};
    vt[3] = '{48'h800000_800000, 48'h800000_800000, 16'hFFFF, 24'h800000, 24'h800000};
`else
    vt[0] = '{48'h100000_100000, 48'hF80000_080000, 16'h8080, 24'h100000, 24'h000000};
    vt[1] = '{48'h123456_400000, 48'h000000_000000, 16'h0040, 24'h100000, 24'h000000};
    vt[2] = '{48'h7FFFFF_7FFFFF, 48'h7FFFFF_7FFFFF, 16'hFFFF, 24'hFEFFFE, 24'hFEFFFE};
    vt[3] = '{48'h800000_800000, 48'h800000_800000, 16'hFFFF, 24'h010000, 24'h010000};
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    hi_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.out_valid || bus.busy || bus.overrun) hi_seen++;
    end
    check("idle_flags", 32'(hi_seen), 32'd0);
    check("idle_l_out", 32'(bus.l_out), 32'd0);
    check("idle_r_out", 32'(bus.r_out), 32'd0);
    for (int i = 0; i < 4; i++) begin
      run_frame(vt[i].l, vt[i].r, vt[i].g, lat, strobes, lo, ro);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd6);
      check($sformatf("vec%0d_strobes", i), 32'(strobes), 32'd1);
      check($sformatf("vec%0d_l_out", i), 32'(lo), 32'(vt[i].el));
      check($sformatf("vec%0d_r_out", i), 32'(ro), 32'(vt[i].er));
    end
    // overrun + snapshot isolation
    @(negedge clk);
    bus.in_l = vt[0].l; bus.in_r = vt[0].r; bus.gain = vt[0].g; bus.frame_start = 1'b1;
    lat = 0; strobes = 0; lo = '0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      bus.frame_start = k == 3;
      if (k == 2) bus.in_l = 48'h7FFFFF_7FFFFF;
      if (k == 4) check("overrun_set", 32'(bus.overrun), 32'd1);
      if (bus.out_valid) begin strobes++; if (lat == 0) begin lat = k; lo = bus.l_out; end end
    end
    check("ovr_latency", 32'(lat), 32'd6);
    check("ovr_strobes", 32'(strobes), 32'd1);
    check("ovr_isolated_l", 32'(lo), 32'(vt[0].el));
    check("overrun_sticky", 32'(bus.overrun), 32'd1);
    bus.overrun_clr = 1'b1;
    @(negedge clk);
    bus.overrun_clr = 1'b0;
    check("overrun_clr", 32'(bus.overrun), 32'd0);
    // back-to-back: second frame launched in the strobe cycle
    l = 48'h200000_F00000; r = 48'h010203_FEDCBA; g = 16'hC040;
    @(negedge clk);
    bus.in_l = vt[0].l; bus.in_r = vt[0].r; bus.gain = vt[0].g; bus.frame_start = 1'b1;
    c1 = 0; c2 = 0; strobes = 0; lo = '0; ro = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      bus.frame_start = 1'b0;
      if (bus.out_valid) begin
        strobes++;
        if (c1 == 0) begin
          c1 = k;
          bus.in_l = l; bus.in_r = r; bus.gain = g; bus.frame_start = 1'b1;
        end else if (c2 == 0) begin c2 = k; lo = bus.l_out; ro = bus.r_out; end
      end
    end
    check("b2b_first", 32'(c1), 32'd6);
    check("b2b_second", 32'(c2), 32'd12);
    check("b2b_strobes", 32'(strobes), 32'd2);
    check("b2b_l_out", 32'(lo), 32'(model(l, g)));
    check("b2b_r_out", 32'(ro), 32'(model(r, g)));
    check("b2b_overrun", 32'(bus.overrun), 32'd0);
    // reset mid-frame
    @(negedge clk);
    bus.in_l = vt[0].l; bus.in_r = vt[0].r; bus.gain = vt[0].g; bus.frame_start = 1'b1;
    strobes = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus.frame_start = 1'b0;
      if (k == 3) begin
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_l_out", 32'(bus.l_out), 32'd0);
      end
      if (k == 4) rst = 1'b0;
      if (bus.out_valid) strobes++;
    end
    check("rst_no_strobe", 32'(strobes), 32'd0);
    run_frame(vt[0].l, vt[0].r, vt[0].g, lat, strobes, lo, ro);
    check("post_rst_latency", 32'(lat), 32'd6);
    check("post_rst_l_out", 32'(lo), 32'(vt[0].el));
    // random frames against the model
    for (int i = 0; i < 30; i++) begin
      l = {rnd_smp(), rnd_smp()};
      r = {rnd_smp(), rnd_smp()};
      g = $urandom_range(0, 3) == 0 ? 16'hFFFF : 16'($urandom);
      el = model(l, g); er = model(r, g);
      run_frame(l, r, g, lat, strobes, lo, ro);
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'd6);
      check($sformatf("rnd%0d_l_out", i), 32'(lo), 32'(el));
      check($sformatf("rnd%0d_r_out", i), 32'(ro), 32'(er));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mix_sequencer.md
# mix_sequencer

Time-multiplexed gain-and-sum engine for the audio mixer. It sits between the per-device I2S receivers and the shared I2S transmit data in the `mclk` domain. Once per stereo frame it snapshots every channel's left/right sample and applies a per-channel gain through a single shared multiplier, stepped by an FSM. It then sums the results and presents one saturated stereo sample to all transmitters.

## Interface

Parameters:
- `NUM_CH`, 2: number of input devices (≥1).
- `DATA_W`, 24: sample width, two's complement.
- `GAIN_W`, 8: gain width, unsigned, Q1.7 (0x80 = unity, 0xFF ≈ 1.992).

Ports:
- `clk` in 1: mixer clock (`mclk` domain).
- `rst` in 1: asynchronous, active-high reset.
- `frame_start` in 1: single-cycle pulse, once per LRCK frame.
- `in_l` in `NUM_CH*DATA_W`: latest left samples; channel k is at bits `[k*DATA_W +: DATA_W]`.
- `in_r` in `NUM_CH*DATA_W`: latest right samples; same packing as `in_l`.
- `gain` in `NUM_CH*GAIN_W`: per-channel gain; channel k is at bits `[k*GAIN_W +: GAIN_W]`.
- `overrun_clr` in 1: clears `overrun`.
- `l_out` out `DATA_W`: mixed left sample.
- `r_out` out `DATA_W`: mixed right sample.
- `out_valid` out 1: one-cycle strobe; `l_out`/`r_out` updated this cycle.
- `busy` out 1: high in any state other than IDLE.
- `overrun` out 1: sticky; set when a frame is dropped.

## Operation

- States: IDLE, MAC_L, MAC_R, FINAL.
- IDLE:
  - On `frame_start`, snapshot `in_l`, `in_r` and `gain` into internal registers.
  - Clear the accumulator, set channel index `ch`=0, go to MAC_L.
- MAC_L:
  - Each cycle: `acc += (snap_l[ch] * {1'b0,gain[ch]}) >>> 7`.
  - The product is a signed `DATA_W+GAIN_W+1`-bit value; the shift is arithmetic, truncating toward −∞.
  - `ch` increments each cycle. After `ch`=`NUM_CH-1`, latch `acc` as `acc_l`, clear `acc`, reset `ch` to 0, go to MAC_R.
- MAC_R:
  - Same operation on `snap_r`.
  - After the last channel, go to FINAL with the right-channel sum in `acc`.
- FINAL:
  - Register `l_out` and `r_out` from the reduction (see Configuration).
  - Pulse `out_valid` and return to IDLE.
- Exactly one multiplier is instantiated and shared by both MAC states.
- Accumulator width: `DATA_W+2+$clog2(NUM_CH)`, signed. It cannot overflow for any input.
- `frame_start` while `busy`:
  - The pulse is ignored; no re-snapshot and the current computation is unaffected.
  - `overrun` is set to 1.
- `overrun`:
  - Stays set until `overrun_clr`=1 or `rst`.
  - If `overrun_clr` and a new overrun coincide in the same cycle, set wins.
- Input changes after the snapshot do not affect the frame in progress.
- Reset values:
  - State IDLE, `ch`=0, accumulators 0.
  - `l_out`=0, `r_out`=0, `out_valid`=0, `busy`=0, `overrun`=0.
- `rst` mid-frame: everything returns to reset values immediately (asynchronously). No `out_valid` is produced for the aborted frame.

## Timing

- Cycle 0 is the rising edge at which `frame_start`=1 is sampled in IDLE.
- Cycles 1..`NUM_CH`: MAC_L.
- Cycles `NUM_CH+1`..`2*NUM_CH`: MAC_R.
- Cycle `2*NUM_CH+1`: FINAL.
- `out_valid`=1 and new `l_out`/`r_out` are visible during cycle `2*NUM_CH+2`. With `NUM_CH`=2 this is 6 cycles after `frame_start`.
- `busy` is high during cycles 1..`2*NUM_CH+1` and low again in the cycle `out_valid` is high. A `frame_start` in that cycle is accepted.
- `l_out`/`r_out` hold their value between strobes.
- Throughput: one frame per `2*NUM_CH+2` cycles. This is far inside one LRCK period, which is 256 `mclk` cycles.

## Configuration

- `MIX_SEQ_SAT_EN` defined:
  - FINAL clamps each sum to [−2^(DATA_W−1), 2^(DATA_W−1)−1], i.e. 0x800000..0x7FFFFF for 24 bits.
  - No channel normalisation is applied.
- `MIX_SEQ_SAT_EN` undefined:
  - FINAL outputs `(sum >>> $clog2(NUM_CH))[DATA_W-1:0]`. This averages the channels, matching a plain halving mixer at `NUM_CH`=2.
  - No clamp is applied; values can wrap when gains exceed unity.

## Test plan

All cases use `NUM_CH`=2 and 24-bit samples.
- Reset/idle: hold `rst`=1, release, apply no stimulus for 20 cycles → `l_out`=`r_out`=0; `out_valid`, `busy` and `overrun` all stay 0.
- Unity mix:
  - Stimulus: both gains 0x80, `in_l`={0x100000, 0x100000}, `in_r`={0x080000, 0xF80000}, one `frame_start` pulse.
  - With SAT_EN: `out_valid` exactly 6 cycles later, `l_out`=0x200000, `r_out`=0x000000.
  - Without SAT_EN: `l_out`=0x100000, `r_out`=0x000000.
- Gain/saturation (SAT_EN):
  - Gains {0x40, 0x00}, `in_l`[0]=0x400000 → `l_out`=0x200000.
  - Gains 0xFF, all inputs 0x7FFFFF → `l_out`=`r_out`=0x7FFFFF.
  - Gains 0xFF, all inputs 0x800000 → `l_out`=`r_out`=0x800000.
- Overrun and snapshot isolation:
  - Second `frame_start` 3 cycles after the first → ignored; single `out_valid` at cycle 6; `overrun`=1.
  - Changing `in_l` at cycle 2 does not alter the result.
  - `overrun_clr` pulse → `overrun`=0.
- Back-to-back frames: `frame_start` asserted in the cycle where `out_valid`=1 → accepted; next `out_valid` 6 cycles later; `overrun` stays 0.
- Reset mid-frame: `rst` pulsed at cycle 3 → `busy`=0 and `l_out`=0 immediately, no `out_valid`; a following `frame_start` completes normally in 6 cycles.
